// File: rtl/mips_run_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller.
// No logic; imported by the interface, the controller and the bench.
// Run states, halt-cause codes and the default halt instruction.
package mips_run_pkg;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_RSTSEQ = 2'd1,
        RS_RUN    = 2'd2,
        RS_DONE   = 2'd3
    } run_state_t;

    typedef logic [1:0] halt_cause_t;

    localparam halt_cause_t HC_NONE  = 2'd0;
    localparam halt_cause_t HC_LIMIT = 2'd1;
    localparam halt_cause_t HC_HALT  = 2'd2;
    localparam halt_cause_t HC_LOOP  = 2'd3;

    // MIPS 'break' encoding.
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000000D;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Signal bundle between the top level / core and mips_run_ctrl.
// Combinational wiring only; slave is the controller side, master the host side.
// No backpressure on any signal; trace pops are fire-and-forget.
interface mips_run_ctrl_if #(
    parameter int XLEN = 32,
    parameter int CW   = 16,
    parameter int TW   = 5
);
    import mips_run_pkg::*;

    logic              start;
    logic [CW-1:0]     cycle_limit;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   instruction;
    logic              core_reset;
    logic              running;
    logic              done;
    halt_cause_t       halt_cause;
    logic [CW-1:0]     cycle_count;
    logic              trace_rd_en;
    logic              trace_rd_valid;
    logic [2*XLEN-1:0] trace_rd_data;
    logic [TW-1:0]     trace_count;

    modport master (
        output start, cycle_limit, pc, pc_next, instruction, trace_rd_en,
        input  core_reset, running, done, halt_cause, cycle_count,
               trace_rd_valid, trace_rd_data, trace_count
    );

    modport slave (
        input  start, cycle_limit, pc, pc_next, instruction, trace_rd_en,
        output core_reset, running, done, halt_cause, cycle_count,
               trace_rd_valid, trace_rd_data, trace_count
    );

endinterface

// File: rtl/mips_run_ctrl_trace_buf.sv
// Circular trace buffer: overwrite-on-full writes, oldest-first pops, synchronous clear.
// Pop data is registered: rd_valid/rd_data appear one cycle after rd_en.
// Never stalls: writes when full drop the oldest entry, pops when empty are ignored.
module mips_trace_buf #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;
    logic          full;
    logic          pop;

    // DEPTH is a power of two, so the count MSB alone flags full.
    assign full   = count[AW];
    assign pop    = rd_en && (count != '0);
    assign rd_idx = wr_ptr - count[AW-1:0];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_idx];
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (wr_en && !pop && !full) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !wr_en) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for mips_core: reset sequencing, stop detection, PC/instruction trace (MIPS_RUN_CTRL_TRACE_EN).
// core_reset released RST_CYCLES edges after start; stop takes effect on the sampling edge; trace pops 1 cycle.
// No backpressure: start is ignored outside IDLE/DONE, trace pops are honoured in DONE only.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CW          = 16,
    parameter int              RST_CYCLES  = 2,
    parameter int              TRACE_DEPTH = 16,
    parameter logic [XLEN-1:0] HALT_WORD   = XLEN'(DEFAULT_HALT_WORD)
) (
    input  logic           clock,
    input  logic           reset,
    mips_run_ctrl_if.slave bus
);
    localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = RS_IDLE;
    localparam logic [1:0] S_RSTSEQ = RS_RSTSEQ;
    localparam logic [1:0] S_RUN    = RS_RUN;
    localparam logic [1:0] S_DONE   = RS_DONE;

    logic [1:0]     state;
    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cycle_count;
    halt_cause_t    halt_cause;
    logic [CW:0]    count_plus1;
    logic           in_run;
    logic           in_done;
    logic           launch;
    halt_cause_t    stop_cause;

    assign in_run      = (state == S_RUN);
    assign in_done     = (state == S_DONE);
    assign launch      = bus.start && ((state == S_IDLE) || in_done);
    assign count_plus1 = {1'b0, cycle_count} + (CW+1)'(1);

    // Priority: halt word, then self-loop, then cycle limit.
    always_comb begin
        stop_cause = HC_NONE;
        if (bus.instruction == HALT_WORD) begin
            stop_cause = HC_HALT;
        end else if (bus.pc_next == bus.pc) begin
            stop_cause = HC_LOOP;
        end else if ((bus.cycle_limit != '0) && (count_plus1 == {1'b0, bus.cycle_limit})) begin
            stop_cause = HC_LIMIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            halt_cause  <= HC_NONE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state       <= S_RSTSEQ;
                        rst_cnt     <= '0;
                        cycle_count <= '0;
                        halt_cause  <= HC_NONE;
                    end
                end
                S_RSTSEQ: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                S_RUN: begin
                    // Carry out of count_plus1 means the counter is saturated.
                    if (!count_plus1[CW]) begin
                        cycle_count <= count_plus1[CW-1:0];
                    end
                    if (stop_cause != HC_NONE) begin
                        state      <= S_DONE;
                        halt_cause <= stop_cause;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_reset  = !in_run;
    assign bus.running     = in_run;
    assign bus.done        = in_done;
    assign bus.halt_cause  = halt_cause;
    assign bus.cycle_count = cycle_count;

`ifdef MIPS_RUN_CTRL_TRACE_EN
    mips_trace_buf #(
        .W     (2*XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clock    (clock),
        .reset    (reset),
        .clear    (launch),
        .wr_en    (in_run),
        .wr_data  ({bus.pc, bus.instruction}),
        .rd_en    (bus.trace_rd_en && in_done),
        .rd_valid (bus.trace_rd_valid),
        .rd_data  (bus.trace_rd_data),
        .count    (bus.trace_count)
    );
`else
    logic trace_rd_en_unused;
    assign trace_rd_en_unused = bus.trace_rd_en;
    assign bus.trace_rd_valid = 1'b0;
    assign bus.trace_rd_data  = '0;
    assign bus.trace_count    = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a queue-based run model checked every cycle.
// Trace expectations follow MIPS_RUN_CTRL_TRACE_EN as seen by this file.
module tb_mips_run_ctrl;
    import mips_run_pkg::*;

    localparam int XLEN  = 32;
    localparam int CW    = 16;
    localparam int RST   = 2;
    localparam int DEPTH = 16;
    localparam int TW    = 5;
    localparam int NEVER = -99;
`ifdef MIPS_RUN_CTRL_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mips_run_ctrl_if #(.XLEN(XLEN), .CW(CW), .TW(TW)) bus ();

    mips_run_ctrl #(
        .XLEN(XLEN), .CW(CW), .RST_CYCLES(RST), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model: a run is "edges since launch" plus a queue of recorded pairs.
    bit          m_active, m_stopped, m_rdv, run_now, run_e, cmp_on;
    int          m_edges, m_cycles, m_cause;
    logic [63:0] m_q[$];
    logic [63:0] m_rdd;

    function automatic bit m_running();
        return m_active && !m_stopped && (m_edges >= RST);
    endfunction

    function automatic int m_count();
        return (m_cycles > 65535) ? 65535 : m_cycles;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_active = 0; m_stopped = 0; m_edges = 0; m_cycles = 0; m_cause = 0;
            m_q.delete(); m_rdv = 0; m_rdd = '0;
        end else begin
            run_now = m_running();
            m_rdv   = 0;
            if (bus.start && (!m_active || m_stopped)) begin
                m_active = 1; m_stopped = 0; m_edges = 0; m_cycles = 0; m_cause = 0;
                m_q.delete(); m_rdd = '0;
            end else if (run_now) begin
                m_cycles++;
                m_q.push_back({bus.pc, bus.instruction});
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
                if (bus.instruction == 32'h0000000D) m_cause = 2;
                else if (bus.pc_next == bus.pc) m_cause = 3;
                else if (bus.cycle_limit != '0 && m_cycles == int'(bus.cycle_limit)) m_cause = 1;
                if (m_cause != 0) m_stopped = 1;
                m_edges++;
            end else if (m_stopped) begin
                if (bus.trace_rd_en && m_q.size() > 0) begin
                    m_rdd = m_q.pop_front();
                    m_rdv = 1;
                end
            end else if (m_active) begin
                m_edges++;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            run_e = m_running();
            chk("running",        64'(bus.running),        64'(run_e));
            chk("core_reset",     64'(bus.core_reset),     64'(!run_e));
            chk("done",           64'(bus.done),           64'(m_stopped));
            chk("halt_cause",     64'(bus.halt_cause),     64'(m_cause));
            chk("cycle_count",    64'(bus.cycle_count),    64'(m_count()));
            chk("trace_count",    64'(bus.trace_count),    64'(TR ? m_q.size() : 0));
            chk("trace_rd_valid", 64'(bus.trace_rd_valid), 64'(TR && m_rdv));
`ifdef MIPS_RUN_CTRL_TRACE_EN
            if (m_rdv) chk("trace_rd_data", bus.trace_rd_data, m_rdd);
`endif
        end
    end

    // Launch a run; run cycle i drives pc = base + 4*(i-1).
    task automatic run(input int limit, input int base, input int halt_at, input int loop_at,
                       input int start_at, input int reset_at, input int ncyc);
        bus.cycle_limit = 16'(limit);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("launch_core_reset", 64'(bus.core_reset),  64'd1);
        chk("launch_count",      64'(bus.cycle_count), 64'd0);
        chk("launch_trace",      64'(bus.trace_count), 64'd0);
        for (int k = 0; k < ncyc; k++) begin
            int i = k - RST + 1;
            logic [31:0] p;
            p = 32'(base + 4 * (i - 1));
            bus.pc          = p;
            bus.pc_next     = (i == loop_at) ? p : p + 32'd4;
            bus.instruction = (i == halt_at) ? 32'h0000000D : 32'h20080000 + 32'(i);
            bus.start       = (i == start_at);
            bus.trace_rd_en = (i == 2);
            reset           = (i == reset_at);
            tick();
            if (k == RST - 1) begin
                chk("release_running",    64'(bus.running),    64'd1);
                chk("release_core_reset", 64'(bus.core_reset), 64'd0);
            end
            if (i == reset_at) begin
                reset = 1'b0;
                bus.trace_rd_en = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
        bus.trace_rd_en = 1'b0;
    endtask

    task automatic pop_check(input string name, input bit exp_v, input logic [31:0] exp_pc);
        bus.trace_rd_en = 1'b1;
        tick();
        chk({name, "_valid"}, 64'(bus.trace_rd_valid), 64'(exp_v));
`ifdef MIPS_RUN_CTRL_TRACE_EN
        if (exp_v) chk({name, "_pc"}, 64'(bus.trace_rd_data[63:32]), 64'(exp_pc));
`endif
    endtask

    task automatic end_check(input string name, input int cause, input int count, input int tcount);
        chk({name, "_done"},   64'(bus.done),        64'd1);
        chk({name, "_cause"},  64'(bus.halt_cause),  64'(cause));
        chk({name, "_count"},  64'(bus.cycle_count), 64'(count));
        chk({name, "_tcount"}, 64'(bus.trace_count), 64'(TR ? tcount : 0));
    endtask

    int t1_pc [5] = '{0, 4, 8, 12, 16};
    int t3_pc [4] = '{32'h34, 32'h38, 32'h3C, 32'h40};

    initial begin
        bus.start = 1'b0; bus.cycle_limit = '0; bus.pc = '0; bus.pc_next = '0;
        bus.instruction = '0; bus.trace_rd_en = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_core_reset", 64'(bus.core_reset),     64'd1);
        chk("rst_running",    64'(bus.running),        64'd0);
        chk("rst_done",       64'(bus.done),           64'd0);
        chk("rst_cause",      64'(bus.halt_cause),     64'd0);
        chk("rst_count",      64'(bus.cycle_count),    64'd0);
        chk("rst_tcount",     64'(bus.trace_count),    64'd0);
        chk("rst_rd_valid",   64'(bus.trace_rd_valid), 64'd0);
        chk("rst_rd_data",    bus.trace_rd_data,       64'd0);
        reset = 1'b0;
        cmp_on = 1'b1;
        tick();

        // Cycle limit of 5, then drain all five entries.
        run(5, 0, NEVER, NEVER, NEVER, NEVER, RST + 6);
        end_check("t1", 1, 5, 5);
        for (int j = 0; j < 5; j++) pop_check("t1_pop", TR, 32'(t1_pc[j]));
        bus.trace_rd_en = 1'b0;
        tick();

        // Halt word on cycle 3 wins over a limit of 3.
        run(3, 32'h100, 3, NEVER, NEVER, NEVER, RST + 4);
        end_check("t2", 2, 3, 3);

        // Self-loop at pc 0x40 on cycle 4 with no limit.
        run(0, 32'h34, NEVER, 4, NEVER, NEVER, RST + 5);
        end_check("t3", 3, 4, 4);
        for (int j = 0; j < 4; j++) pop_check("t3_pop", TR, 32'(t3_pc[j]));
        bus.trace_rd_en = 1'b0;
        tick();

        // Overflowing the trace keeps cycles 5..20; a 17th pop finds it empty.
        run(20, 0, NEVER, NEVER, NEVER, NEVER, RST + 21);
        end_check("t4", 1, 20, 16);
        for (int j = 0; j < 16; j++) pop_check("t4_pop", TR, 32'(16 + 4 * j));
        pop_check("t4_empty", 1'b0, 32'd0);
        bus.trace_rd_en = 1'b0;
        tick();

        // Reset mid-run, then a normal short run.
        run(0, 0, NEVER, NEVER, NEVER, 3, RST + 10);
        chk("t5_core_reset", 64'(bus.core_reset),  64'd1);
        chk("t5_running",    64'(bus.running),     64'd0);
        chk("t5_done",       64'(bus.done),        64'd0);
        chk("t5_count",      64'(bus.cycle_count), 64'd0);
        chk("t5_tcount",     64'(bus.trace_count), 64'd0);
        tick();
        run(2, 0, NEVER, NEVER, NEVER, NEVER, RST + 3);
        end_check("t5b", 1, 2, 2);

        // Start during RUN is ignored; start in DONE relaunches with a clean trace.
        run(4, 0, NEVER, NEVER, 2, NEVER, RST + 5);
        end_check("t6", 1, 4, 4);
        run(3, 32'h200, NEVER, NEVER, NEVER, NEVER, RST + 4);
        end_check("t6b", 1, 3, 3);
        pop_check("t6b_pop", TR, 32'h200);
        bus.trace_rd_en = 1'b0;
        tick();

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
